mips_alu_seq: RTL and testbench

- Parametrised, clocked successor to the basic MIPS ALU.
- Supports the full R-type logic, arithmetic, shift and compare set as single-cycle registered ops.
- Supports iterative MULT/MULTU/DIV/DIVU writing HI/LO; these are multi-cycle.
- Sits in the EX stage. The stall controller uses busy/done to hold the pipeline during multi-cycle ops.

---
 rtl/mips_alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_mips_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_seq.sv
// EX-stage ALU: single-cycle ops registered at the start edge, MULT/DIV iterate one bit per cycle (WIDTH+1 cycles).
// No backpressure: start is ignored while busy; done pulses for one cycle when results are valid.
`timescale 1ns/1ps
module mips_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb, a_save;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, div0;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, dif, sc_res;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf;

  assign sum   = A + B;
  assign dif   = A - B;
  assign shamt = A[SHW-1:0];

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUctl)
      4'd0:  sc_res = A & B;
      4'd1:  sc_res = A | B;
      4'd2: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd3:  sc_res = A ^ B;
      4'd4:  sc_res = B << shamt;
      4'd5:  sc_res = B >> shamt;
      4'd6: begin
        sc_res = dif;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      4'd7:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd8:  sc_res = $signed(B) >>> shamt;
      4'd9:  sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd12: sc_res = ~(A | B);
      default: sc_res = '0;
    endcase
  end

  // Operand conditioning for the iterative units
  logic             is_mul_op, is_div_op, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_mul_op = (ALUctl == 4'd10) || (ALUctl == 4'd11);
  assign is_div_op = (ALUctl == 4'd13) || (ALUctl == 4'd14);
  assign is_signed = (ALUctl == 4'd10) || (ALUctl == 4'd13);
  assign a_neg     = is_signed && A[WIDTH-1];
  assign b_neg     = is_signed && B[WIDTH-1];
  assign mag_a     = a_neg ? (~A + 1'b1) : A;
  assign mag_b     = b_neg ? (~B + 1'b1) : B;

  // acc_hi is the partial product / remainder, acc_lo the multiplier / quotient
  logic [WIDTH:0] mul_sum, div_sh, div_df;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_df  = div_sh - {1'b0, opb};

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   hi_fin, lo_fin;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    hi_fin = prod_fix[2*WIDTH-1:WIDTH];
    lo_fin = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        hi_fin = a_save;
        lo_fin = '1;
      end else begin
        hi_fin = neg_r ? (~acc_hi + 1'b1) : acc_hi;
        lo_fin = neg_q ? (~acc_lo + 1'b1) : acc_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ALUOut   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      a_save   <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op || is_div_op) begin
              acc_hi <= '0;
              acc_lo <= mag_a;
              opb    <= mag_b;
              a_save <= A;
              cnt    <= '0;
              is_div <= is_div_op;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              div0   <= (B == '0);
              busy   <= 1'b1;
              state  <= is_div_op ? DIV : MUL;
            end else begin
              ALUOut   <= sc_res;
              Zero     <= (sc_res == '0);
              Overflow <= sc_ovf;
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          if (!div_df[WIDTH]) begin
            acc_hi <= div_df[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          HI       <= hi_fin;
          LO       <= lo_fin;
          ALUOut   <= lo_fin;
          Zero     <= (lo_fin == '0);
          Overflow <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Scoreboard bench for mips_alu_seq: expected results queued at issue, compared when done pulses.
`timescale 1ns/1ps
module tb_mips_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [3:0]   ALUctl;
  logic [W-1:0] A, B, ALUOut, HI, LO;
  logic         Zero, Overflow, busy, done;

  always #5 clk = ~clk;

  mips_alu_seq #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUctl(ALUctl), .A(A), .B(B),
    .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow), .HI(HI), .LO(LO),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         multi;
  } exp_t;

  exp_t         sq[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint s;
    logic [63:0] p;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    e = '0;
    e.hi = m_hi;
    e.lo = m_lo;
    case (op)
      4'd0: e.out = a & b;
      4'd1: e.out = a | b;
      4'd2: begin
        e.out = a + b;
        s = longint'(sa) + longint'(sb);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: e.out = a ^ b;
      4'd4: e.out = b << a[4:0];
      4'd5: e.out = b >> a[4:0];
      4'd6: begin
        e.out = a - b;
        s = longint'(sa) - longint'(sb);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: e.out = (sa < sb) ? 1 : 0;
      4'd8: e.out = sb >>> a[4:0];
      4'd9: e.out = (a < b) ? 1 : 0;
      4'd12: e.out = ~(a | b);
      4'd10: begin
        p = longint'(sa) * longint'(sb);
        e.hi = p[63:32]; e.lo = p[31:0]; e.multi = 1'b1;
      end
      4'd11: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.multi = 1'b1;
      end
      4'd13, 4'd14: begin
        e.multi = 1'b1;
        if (b == 0) begin
          e.lo = '1; e.hi = a;
        end else if (op == 4'd13 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a; e.hi = '0;
        end else if (op == 4'd13) begin
          e.lo = sa / sb; e.hi = sa % sb;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: e.out = '0;
    endcase
    if (e.multi) e.out = e.lo;
    e.zero = (e.out == 0);
    return e;
  endfunction

  // Called at a negedge; returns just after the start edge with the inputs scrambled
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(op, a, b);
    sq.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    ALUctl = op; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = ~a; B = a ^ b; ALUctl = 4'd15;
  endtask

  task automatic wait_done(input string tag, input int poke_at);
    int n, nbusy;
    bit got;
    exp_t e;
    n = 0; nbusy = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (start) start = 1'b0;
      if (busy) nbusy++;
      if (done) got = 1;
      else if (n == poke_at) begin
        start = 1'b1; ALUctl = 4'd0; A = '1; B = '1;
      end
    end
    check_eq({tag, "_done_seen"}, got, 1);
    if (got && sq.size() > 0) begin
      e = sq.pop_front();
      check_eq({tag, "_latency"}, n, e.multi ? W + 2 : 1);
      check_eq({tag, "_busy_cycles"}, nbusy, e.multi ? W + 1 : 0);
      check_eq({tag, "_aluout"}, ALUOut, e.out);
      check_eq({tag, "_zero"}, Zero, e.zero);
      check_eq({tag, "_ovf"}, Overflow, e.ovf);
      check_eq({tag, "_hi"}, HI, e.hi);
      check_eq({tag, "_lo"}, LO, e.lo);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_aluout"}, ALUOut, 0);
    check_eq({tag, "_zero"}, Zero, 1);
    check_eq({tag, "_ovf"}, Overflow, 0);
    check_eq({tag, "_hi"}, HI, 0);
    check_eq({tag, "_lo"}, LO, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; ALUctl = '0; A = '0; B = '0;
    #22;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    issue(4'd2, 32'h7FFF_FFFF, 32'h1);        wait_done("add_ovf", 0);
    issue(4'd6, 32'd5, 32'd5);                wait_done("sub_zero", 0);
    issue(4'd6, 32'h8000_0000, 32'h1);        wait_done("sub_ovf", 0);
    issue(4'd7, 32'hFFFF_FFFF, 32'h1);        wait_done("slt", 0);
    issue(4'd9, 32'hFFFF_FFFF, 32'h1);        wait_done("sltu", 0);
    issue(4'd8, 32'd4, 32'h8000_0000);        wait_done("sra", 0);
    issue(4'd4, 32'h21, 32'h1);               wait_done("sll", 0);
    issue(4'd5, 32'h3F, 32'hF000_0000);       wait_done("srl", 0);
    issue(4'd12, 32'h0F0F_0000, 32'h0000_F0F0); wait_done("nor", 0);
    issue(4'd15, 32'h1234, 32'h5678);         wait_done("reserved", 0);

    issue(4'd10, 32'hFFFF_FFFD, 32'd7);       wait_done("mult_poke", 5);
    @(negedge clk);
    check_eq("mult_no_second_done", done, 0);
    check_eq("mult_no_second_busy", busy, 0);

    issue(4'd13, 32'hFFFF_FFF9, 32'd2);       wait_done("div", 0);
    issue(4'd14, 32'd9, 32'd0);               wait_done("divu_by0", 0);
    issue(4'd13, 32'hFFFF_FFF9, 32'd0);       wait_done("div_by0", 0);
    issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_minneg", 0);
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("multu", 0);
    issue(4'd0, 32'hAAAA_5555, 32'hFFFF_0000); wait_done("and_b2b", 0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      issue(rop, ra, rb);
      wait_done("rand", 0);
    end

    issue(4'd14, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    void'(sq.pop_front());
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    issue(4'd0, 32'h0000_F0F0, 32'h0000_FF00); wait_done("and_after_reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
